multicycle_controller: RTL
==========================

Name: multicycle_controller

Overview:
- Main control FSM plus instruction decoders for the multicycle RV32I core.
- Each cycle it drives every datapath select/enable from the current state and the latched instruction fields (op, funct3, funct7b5) and the ALU Zero flag.
- Supported instructions: lw, sw, R-type ALU, I-type ALU, beq, jal.
- Sits beside the datapath inside riscvmulti and replaces its controller instance one-for-one.

Parameters:
- None. Encodings are fixed by the datapath and come from the shared package.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- op  in  7  Instr[6:0]
- funct3  in  3  Instr[14:12]
- funct7b5  in  1  Instr[30]
- Zero  in  1  ALU zero flag
- ImmSrc  out  2  immediate format: 00 I, 01 S, 10 B, 11 J
- ALUSrcA  out  2  ALU A select: 00 PC, 01 OldPC, 10 A register
- ALUSrcB  out  2  ALU B select: 00 WriteData, 01 ImmExt, 10 constant 4
- ResultSrc  out  2  result select: 00 ALUOut, 01 Data, 10 ALUResult
- AdrSrc  out  1  memory address select: 0 PC, 1 Result
- ALUControl  out  3  000 add, 001 sub, 010 and, 011 or, 100 xor, 101 slt, 110 sll, 111 srl
- IRWrite  out  1  latch Instr and OldPC
- PCWrite  out  1  load PC
- RegWrite  out  1  register file write enable
- MemWrite  out  1  memory write enable

Behaviour:
- Moore FSM; state register is the only storage. All outputs are combinational from state, op, funct3, funct7b5 and Zero.
- Internal signals: ALUOp (2 bits), PCUpdate, Branch. PCWrite = PCUpdate | (Branch & Zero).
- Any signal not listed for a state is 0.

States and outputs:
- FETCH: AdrSrc=0, IRWrite=1, SrcA=00, SrcB=10, ALUOp=00, ResultSrc=10, PCUpdate=1. Next state DECODE.
- DECODE: SrcA=01, SrcB=01, ALUOp=00; ALUOut captures the branch/jump target.
  - Next: lw/sw -> MEMADR; R -> EXECUTER; I -> EXECUTEI; beq -> BEQ; jal -> JAL.
  - Any other opcode -> FETCH (instruction skipped; PC is already +4).
- MEMADR: SrcA=10, SrcB=01, ALUOp=00. Next: lw -> MEMREAD, sw -> MEMWRITE.
- MEMREAD: ResultSrc=00, AdrSrc=1. Next MEMWB.
- MEMWB: ResultSrc=01, RegWrite=1. Next FETCH.
- MEMWRITE: ResultSrc=00, AdrSrc=1, MemWrite=1. Next FETCH.
- EXECUTER: SrcA=10, SrcB=00, ALUOp=10. Next ALUWB.
- EXECUTEI: SrcA=10, SrcB=01, ALUOp=10. Next ALUWB.
- ALUWB: ResultSrc=00, RegWrite=1. Next FETCH.
- BEQ: SrcA=10, SrcB=00, ALUOp=01, ResultSrc=00, Branch=1. Next FETCH.
- JAL: SrcA=01, SrcB=10, ALUOp=00, ResultSrc=00, PCUpdate=1. Next ALUWB (rd = OldPC+4).

Opcodes:
- lw 0000011, sw 0100011, R 0110011, I 0010011, beq 1100011, jal 1101111.

ImmSrc (from op, independent of state):
- sw 01, beq 10, jal 11, all others 00.

ALU decoder:
- ALUOp 00 -> add; 01 -> sub.
- ALUOp 10, by funct3:
  - 000: sub if (op[5] & funct7b5), else add
  - 001: sll
  - 010: slt
  - 100: xor
  - 101: srl
  - 110: or
  - 111: and
  - 011: add

Latency in cycles (FETCH through last state):
- lw 5; sw, R, I, jal 4; beq 3; illegal opcode 2.

Reset:
- At a clock edge with reset=1, the state becomes FETCH, from any state, including mid-instruction.
- While reset=1, MemWrite, RegWrite, PCWrite and IRWrite are forced to 0 combinationally. This prevents a partial store or writeback.
- After reset deasserts, the first cycle is FETCH.
- Unreachable state encodings go to FETCH with all enables 0.

Optional Feature:
- Macro: MULTICYCLE_BNE_EN.
- Defined: beq opcode with funct3=001 (bne) also enters the BEQ state, and PCWrite = PCUpdate | (Branch & ~Zero).
- Not defined: beq opcode with funct3 other than 000 is treated as illegal (DECODE -> FETCH). The funct3=000 path is identical in both builds.

Decomposition:
- Package multicycle_pkg holds:
  - statetype enum
  - opcode localparams
  - ALUOp and ALUControl localparams
  - ImmSrc, ALUSrcA/B and ResultSrc encodings
- Sub-module alu_decoder (ALUOp, funct3, op5, funct7b5 -> ALUControl) is purely combinational. Instantiate it once.

Test Plan:
- Reset held 2 cycles, then released -> first cycle is FETCH with IRWrite=1, PCWrite=1, ALUSrcB=10, ResultSrc=10; MemWrite=RegWrite=0 throughout reset.
- add/sub: op=0110011, funct3=000, funct7b5=1 -> states FETCH, DECODE, EXECUTER (ALUControl=001), ALUWB (RegWrite=1); 4 cycles. The same with funct7b5=1 on op=0010011 -> ALUControl=000.
- lw then sw -> lw takes 5 cycles, MEMWB with ResultSrc=01; sw takes 4 cycles, MEMWRITE with MemWrite=1, AdrSrc=1, ImmSrc=01.
- beq: Zero=1 in BEQ -> PCWrite=1, ALUControl=001. Zero=0 -> PCWrite=0. Both return to FETCH after 3 cycles. With MULTICYCLE_BNE_EN: funct3=001 gives the inverse result; without it, funct3=001 takes 2 cycles and asserts no Branch.
- jal: op=1101111 -> ImmSrc=11; JAL state with PCWrite=1, ALUSrcA=01, ALUSrcB=10; then ALUWB with RegWrite=1.
- Illegal op 1111111 -> DECODE goes to FETCH; no RegWrite or MemWrite. Reset asserted in MEMWRITE -> MemWrite drops to 0 the same cycle, state is FETCH next cycle.

Source files
------------

// File: rtl/multicycle_pkg.sv
// Shared encodings for the multicycle RV32I controller: FSM states, opcodes,
// ALU operation codes and datapath select encodings.
// Optional feature macro: MULTICYCLE_BNE_EN (bne shares the BEQ state).
package multicycle_pkg;

    // Main FSM states. Encodings 11..15 are unreachable and recover to FETCH.
    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTER = 4'd6,
        S_EXECUTEI = 4'd7,
        S_ALUWB    = 4'd8,
        S_BEQ      = 4'd9,
        S_JAL      = 4'd10
    } statetype;

    // Opcodes (Instr[6:0])
    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    // Branch funct3 values
    localparam logic [2:0] F3_BEQ = 3'b000;
    localparam logic [2:0] F3_BNE = 3'b001;

    // ALUOp: what the main FSM asks of the ALU decoder
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    // ALUControl encodings understood by the datapath ALU
    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_XOR = 3'b100;
    localparam logic [2:0] ALU_SLT = 3'b101;
    localparam logic [2:0] ALU_SLL = 3'b110;
    localparam logic [2:0] ALU_SRL = 3'b111;

    // Immediate formats
    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

    // ALU source A select
    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_REG   = 2'b10;

    // ALU source B select
    localparam logic [1:0] SRCB_WD   = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    // Result select
    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    // Immediate format depends only on the opcode, never on the state.
    function automatic logic [1:0] imm_src_for(input logic [6:0] opcode);
        case (opcode)
            OP_SW:   return IMM_S;
            OP_BEQ:  return IMM_B;
            OP_JAL:  return IMM_J;
            default: return IMM_I;
        endcase
    endfunction

endpackage

// File: rtl/alu_decoder.sv
// ALU decoder: turns the FSM's ALUOp plus funct3/op[5]/funct7b5 into the
// 3-bit ALUControl code. Purely combinational.
module alu_decoder
    import multicycle_pkg::*;
(
    input  logic [1:0] ALUOp,
    input  logic [2:0] funct3,
    input  logic       op5,
    input  logic       funct7b5,
    output logic [2:0] ALUControl
);

    // Select the ALU operation; R-type funct3=000 with funct7b5 set is sub.
    always_comb begin
        // NOTE: a default assignment before the case keeps every path driven, so no latch is inferred.
        ALUControl = ALU_ADD;
        case (ALUOp)
            ALUOP_ADD: ALUControl = ALU_ADD;
            ALUOP_SUB: ALUControl = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct3)
                    3'b000:  ALUControl = (op5 & funct7b5) ? ALU_SUB : ALU_ADD;
                    3'b001:  ALUControl = ALU_SLL;
                    3'b010:  ALUControl = ALU_SLT;
                    3'b011:  ALUControl = ALU_ADD;
                    3'b100:  ALUControl = ALU_XOR;
                    3'b101:  ALUControl = ALU_SRL;
                    3'b110:  ALUControl = ALU_OR;
                    3'b111:  ALUControl = ALU_AND;
                    default: ALUControl = ALU_ADD;
                endcase
            end
            default: ALUControl = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Main control FSM for the multicycle RV32I core (lw, sw, R, I, beq, jal).
// Moore FSM: the state register is the only storage; every output is
// combinational from state, op, funct3, funct7b5 and Zero.
// Optional feature macro: MULTICYCLE_BNE_EN - bne (beq opcode, funct3=001)
// also uses the BEQ state and branches when Zero is clear.
module multicycle_controller
    import multicycle_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       Zero,
    output logic [1:0] ImmSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ResultSrc,
    output logic       AdrSrc,
    output logic [2:0] ALUControl,
    output logic       IRWrite,
    output logic       PCWrite,
    output logic       RegWrite,
    output logic       MemWrite
);

    statetype   state;
    statetype   next_state;

    logic [1:0] alu_op;
    logic       pc_update;
    logic       branch;
    logic       ir_write_raw;
    logic       reg_write_raw;
    logic       mem_write_raw;
    logic       branch_legal;
    logic       branch_taken;

`ifdef MULTICYCLE_BNE_EN
    assign branch_legal = (funct3 == F3_BEQ) || (funct3 == F3_BNE);
    assign branch_taken = (funct3 == F3_BNE) ? ~Zero : Zero;
`else
    assign branch_legal = (funct3 == F3_BEQ);
    assign branch_taken = Zero;
`endif

    // State register with synchronous reset back to FETCH.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
        if (reset) begin
            state <= S_FETCH;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic; unknown opcodes and stray encodings return to FETCH.
    always_comb begin
        next_state = S_FETCH;
        case (state)
            S_FETCH: next_state = S_DECODE;
            S_DECODE: begin
                case (op)
                    OP_LW, OP_SW: next_state = S_MEMADR;
                    OP_R:         next_state = S_EXECUTER;
                    OP_I:         next_state = S_EXECUTEI;
                    OP_BEQ:       next_state = branch_legal ? S_BEQ : S_FETCH;
                    OP_JAL:       next_state = S_JAL;
                    default:      next_state = S_FETCH;
                endcase
            end
            S_MEMADR:   next_state = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD:  next_state = S_MEMWB;
            S_MEMWB:    next_state = S_FETCH;
            S_MEMWRITE: next_state = S_FETCH;
            S_EXECUTER: next_state = S_ALUWB;
            S_EXECUTEI: next_state = S_ALUWB;
            S_ALUWB:    next_state = S_FETCH;
            S_BEQ:      next_state = S_FETCH;
            S_JAL:      next_state = S_ALUWB;
            default:    next_state = S_FETCH;
        endcase
    end

    // Per-state datapath selects and raw enables; unlisted signals stay 0.
    always_comb begin
        ALUSrcA       = SRCA_PC;
        ALUSrcB       = SRCB_WD;
        ResultSrc     = RES_ALUOUT;
        AdrSrc        = 1'b0;
        alu_op        = ALUOP_ADD;
        pc_update     = 1'b0;
        branch        = 1'b0;
        ir_write_raw  = 1'b0;
        reg_write_raw = 1'b0;
        mem_write_raw = 1'b0;
        case (state)
            S_FETCH: begin
                AdrSrc       = 1'b0;
                ir_write_raw = 1'b1;
                ALUSrcA      = SRCA_PC;
                ALUSrcB      = SRCB_FOUR;
                alu_op       = ALUOP_ADD;
                ResultSrc    = RES_ALURESULT;
                pc_update    = 1'b1;
            end
            S_DECODE: begin
                // ALUOut captures OldPC + imm as the branch/jump target.
                ALUSrcA = SRCA_OLDPC;
                ALUSrcB = SRCB_IMM;
                alu_op  = ALUOP_ADD;
            end
            S_MEMADR: begin
                ALUSrcA = SRCA_REG;
                ALUSrcB = SRCB_IMM;
                alu_op  = ALUOP_ADD;
            end
            S_MEMREAD: begin
                ResultSrc = RES_ALUOUT;
                AdrSrc    = 1'b1;
            end
            S_MEMWB: begin
                ResultSrc     = RES_DATA;
                reg_write_raw = 1'b1;
            end
            S_MEMWRITE: begin
                ResultSrc     = RES_ALUOUT;
                AdrSrc        = 1'b1;
                mem_write_raw = 1'b1;
            end
            S_EXECUTER: begin
                ALUSrcA = SRCA_REG;
                ALUSrcB = SRCB_WD;
                alu_op  = ALUOP_FUNCT;
            end
            S_EXECUTEI: begin
                ALUSrcA = SRCA_REG;
                ALUSrcB = SRCB_IMM;
                alu_op  = ALUOP_FUNCT;
            end
            S_ALUWB: begin
                ResultSrc     = RES_ALUOUT;
                reg_write_raw = 1'b1;
            end
            S_BEQ: begin
                ALUSrcA   = SRCA_REG;
                ALUSrcB   = SRCB_WD;
                alu_op    = ALUOP_SUB;
                ResultSrc = RES_ALUOUT;
                branch    = 1'b1;
            end
            S_JAL: begin
                // rd receives OldPC + 4 via ALUOut in the following ALUWB.
                ALUSrcA   = SRCA_OLDPC;
                ALUSrcB   = SRCB_FOUR;
                alu_op    = ALUOP_ADD;
                ResultSrc = RES_ALUOUT;
                pc_update = 1'b1;
            end
            default: begin
                ALUSrcA = SRCA_PC;
            end
        endcase
    end

    // Immediate format is decoded straight from the opcode.
    assign ImmSrc = imm_src_for(op);

    alu_decoder u_alu_decoder (
        .ALUOp      (alu_op),
        .funct3     (funct3),
        .op5        (op[5]),
        .funct7b5   (funct7b5),
        .ALUControl (ALUControl)
    );

    // Reset masks every architectural write so an interrupted instruction
    // cannot leave a partial store or writeback behind.
    assign IRWrite  = ~reset & ir_write_raw;
    assign PCWrite  = ~reset & (pc_update | (branch & branch_taken));
    assign RegWrite = ~reset & reg_write_raw;
    assign MemWrite = ~reset & mem_write_raw;

endmodule
